fft12_frame_ctrl: RTL and testbench
===================================

Name: fft12_frame_ctrl

Overview:
Frame sequencer for the 12-point combinational FFT datapath. It accepts a serial complex sample stream with a valid/ready handshake and collects 12 samples into an input frame register. It presents that frame in parallel to the FFT core, waits a fixed settle latency, captures the 12 bins, and streams them out serially in natural bin order. Input and output buffers are separate, so the next frame fills while the current frame drains.

Parameters:
W, 16, sample/bin width (two's complement, per real/imag component)
CORE_LAT, 1, cycles between the core inputs becoming stable and output capture; range 1..7

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_re  in  W  sample real part
in_im  in  W  sample imaginary part
in_last  in  1  marks sample 12 of a frame
core_x_re  out  12*W  frame to core, real; sample k at bits [k*W +: W]
core_x_im  out  12*W  frame to core, imag; same packing
core_X_re  in  12*W  core bins, real; bin k at bits [k*W +: W]
core_X_im  in  12*W  core bins, imag; same packing
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts the bin
out_re  out  W  bin real part
out_im  out  W  bin imaginary part
out_last  out  1  high with bin 11
err_len  out  1  one-cycle pulse on a frame-length violation

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_last=0, err_len=0, out_re/out_im=0, core_x_re/core_x_im=0, fill index=0, drain index=0. A reset mid-operation discards any partial input frame and any pending output frame.
- Transfers: an input transfer is in_valid&&in_ready; an output transfer is out_valid&&out_ready.

Input FSM (states FILL, FULL, SETTLE):
- FILL: in_ready=1. Each input transfer writes sample[idx] and increments idx.
- in_last at idx<11: sample is discarded, idx←0, err_len pulses the next cycle, stay in FILL.
- Transfer at idx==11: sample stored, idx←0. If in_last=0, err_len pulses but the frame is still accepted. Go to SETTLE if the output buffer is empty (including an output buffer freeing on this same cycle), else to FULL.
- FULL: in_ready=0; wait until the output buffer is empty, then go to SETTLE.
- SETTLE: in_ready=0; the input frame register stays stable on core_x_*. Load counter=CORE_LAT; when it reaches 1, capture core_X_* into the output buffer, mark it full, and return to FILL.
- Latency: last input transfer to first out_valid is CORE_LAT+1 cycles when the output buffer is empty.

Output side:
- While the output buffer is full: out_valid=1, out_re/out_im=bin[didx], out_last=(didx==11).
- Each output transfer increments didx.
- Transfer at didx==11: didx←0, buffer empty, out_valid=0 the next cycle, unless a capture occurs that same cycle (that cannot happen, because capture requires an empty buffer).
- With out_valid=1 and out_ready=0, all out_* hold.

Arithmetic: no arithmetic beyond the index counters (4-bit, wrap at 11) and the settle counter (3-bit). Data passes through bit-exact.

Optional Feature:
Macro FFT12_FRAME_TAG_EN.
- Defined: extra output port out_tag [7:0]. It is a frame sequence number, reset 0, incremented on each capture (wraps 255→0), held constant across the 12 bins of that frame.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fft12_pkg: constant FFT_N=12, typedef cplx_t {logic signed [W-1:0] re, im}, enum in_state_t {FILL, FULL, SETTLE}, and an index width constant IDX_W=4.
- One natural sub-module: fft12_out_serializer. It holds the 12-entry output buffer, the drain index, and the valid/ready/last logic. The top level keeps the input FSM and the frame register.

Test Plan:
- Impulse: sample0=(1000,0), samples 1..11=0, CORE_LAT=1 with a golden core → 12 bins all (1000,0); first out_valid 2 cycles after the last input; out_last only on bin 11.
- DC frame: all 12 samples (100,0) → bin0=(1200,0), bins 1..11=(0,0).
- Backpressure: out_ready=0 for 5 cycles during bin 3 → out_re/out_im/out_last hold; exactly 12 bins delivered; no duplicates or losses.
- Early in_last on sample 5 → err_len single pulse, partial frame dropped; the next 12-sample frame (alternating ±100) yields bin6=(1200,0) and all other bins zero.
- Overlap: second frame fully input while frame 1 drains with out_ready=0 → in_ready=0 after its 12th sample (FULL); SETTLE starts on the cycle frame 1's bin 11 is accepted.
- Reset asserted at bin 7 of a drain → next cycle out_valid=0 and in_ready=1; a fresh frame then processes normally from bin 0.

Source files
------------

// File: rtl/fft12_pkg.sv
// Shared constants and types for the 12-point FFT frame controller.
package fft12_pkg;

  localparam int FFT_N  = 12;
  localparam int IDX_W  = 4;
  localparam int CPLX_W = 16;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_N - 1);

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    FILL,
    FULL,
    SETTLE
  } in_state_t;

endpackage

// File: rtl/fft12_frame_ctrl_if.sv
// Serial sample/bin streams and error strobe of fft12_frame_ctrl.
// With FFT12_FRAME_TAG_EN defined the bin stream also carries out_tag.
interface fft12_frame_ctrl_if #(
  parameter int W = 16
) ();

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                in_last;

  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_last;
  logic                err_len;
`ifdef FFT12_FRAME_TAG_EN
  logic [7:0]          out_tag;
`endif

  modport slave (
`ifdef FFT12_FRAME_TAG_EN
    output out_tag,
`endif
    input  in_valid, in_re, in_im, in_last, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last, err_len
  );

  modport master (
`ifdef FFT12_FRAME_TAG_EN
    input  out_tag,
`endif
    output in_valid, in_re, in_im, in_last, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last, err_len
  );

endinterface

// File: rtl/fft12_out_serializer.sv
// 12-entry bin buffer drained serially with valid/ready; avail_o tells the input
// side the buffer is (or becomes this cycle) empty. FFT12_FRAME_TAG_EN adds out_tag_o.
module fft12_out_serializer
  import fft12_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_i,
  input  logic [FFT_N*W-1:0]  cap_re_i,
  input  logic [FFT_N*W-1:0]  cap_im_i,
  input  logic                out_ready_i,
  output logic                out_valid_o,
  output logic signed [W-1:0] out_re_o,
  output logic signed [W-1:0] out_im_o,
  output logic                out_last_o,
`ifdef FFT12_FRAME_TAG_EN
  output logic [7:0]          out_tag_o,
`endif
  output logic                avail_o
);

  logic                full_q, full_d;
  logic [IDX_W-1:0]    didx_q, didx_d;
  logic signed [W-1:0] bin_re_q [FFT_N];
  logic signed [W-1:0] bin_im_q [FFT_N];
  logic                at_last;
  logic                xfer;

  assign at_last = (didx_q == IDX_LAST);
  assign xfer    = full_q && out_ready_i;

  always_comb begin
    full_d = full_q;
    didx_d = didx_q;
    if (xfer) begin
      if (at_last) begin
        full_d = 1'b0;
        didx_d = '0;
      end else begin
        didx_d = didx_q + IDX_W'(1);
      end
    end
    // Capture is only issued into an empty buffer, so it never races a drain.
    if (cap_i) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      didx_q <= '0;
    end else begin
      full_q <= full_d;
      didx_q <= didx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_i) begin
      for (int k = 0; k < FFT_N; k++) begin
        bin_re_q[k] <= cap_re_i[k*W +: W];
        bin_im_q[k] <= cap_im_i[k*W +: W];
      end
    end
  end

  // Data is gated by full so the outputs read zero after reset without clearing the buffer.
  assign out_valid_o = full_q;
  assign out_re_o    = full_q ? bin_re_q[didx_q] : '0;
  assign out_im_o    = full_q ? bin_im_q[didx_q] : '0;
  assign out_last_o  = full_q && at_last;
  assign avail_o     = !full_q || (out_ready_i && at_last);

`ifdef FFT12_FRAME_TAG_EN
  logic [7:0] tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (cap_i) begin
      tag_d = tag_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign out_tag_o = tag_q;
`endif

endmodule

// File: rtl/fft12_frame_ctrl.sv
// Frame sequencer for the 12-point combinational FFT: collects 12 samples, lets the
// core settle CORE_LAT cycles, captures the bins. Optional macro: FFT12_FRAME_TAG_EN.
module fft12_frame_ctrl
  import fft12_pkg::*;
#(
  parameter int W        = 16,
  parameter int CORE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  fft12_frame_ctrl_if.slave  fc,
  output logic [FFT_N*W-1:0] core_x_re,
  output logic [FFT_N*W-1:0] core_x_im,
  input  logic [FFT_N*W-1:0] core_X_re,
  input  logic [FFT_N*W-1:0] core_X_im
);

  localparam logic [2:0] CNT_LOAD = 3'(CORE_LAT);

  in_state_t           state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wr_en;
  logic                cap;
  logic                avail;
  logic                in_xfer;
  logic signed [W-1:0] x_re_q [FFT_N];
  logic signed [W-1:0] x_im_q [FFT_N];

  assign fc.in_ready = (state_q == FILL);
  assign fc.err_len  = err_q;
  assign in_xfer     = fc.in_valid && (state_q == FILL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      FILL: begin
        if (in_xfer) begin
          if (idx_q == IDX_LAST) begin
            // Twelfth sample always completes the frame; a missing in_last is only flagged.
            wr_en   = 1'b1;
            idx_d   = '0;
            err_d   = !fc.in_last;
            cnt_d   = CNT_LOAD;
            state_d = avail ? SETTLE : FULL;
          end else if (fc.in_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (avail) begin
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 3'd1) begin
          cap     = 1'b1;
          state_d = FILL;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Frame register drives the core directly and is held stable through SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FFT_N; k++) begin
        x_re_q[k] <= '0;
        x_im_q[k] <= '0;
      end
    end else if (wr_en) begin
      x_re_q[idx_q] <= fc.in_re;
      x_im_q[idx_q] <= fc.in_im;
    end
  end

  always_comb begin
    core_x_re = '0;
    core_x_im = '0;
    for (int k = 0; k < FFT_N; k++) begin
      core_x_re[k*W +: W] = x_re_q[k];
      core_x_im[k*W +: W] = x_im_q[k];
    end
  end

  fft12_out_serializer #(
    .W (W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .cap_i       (cap),
    .cap_re_i    (core_X_re),
    .cap_im_i    (core_X_im),
    .out_ready_i (fc.out_ready),
    .out_valid_o (fc.out_valid),
    .out_re_o    (fc.out_re),
    .out_im_o    (fc.out_im),
    .out_last_o  (fc.out_last),
`ifdef FFT12_FRAME_TAG_EN
    .out_tag_o   (fc.out_tag),
`endif
    .avail_o     (avail)
  );

endmodule

// File: tb/tb_fft12_frame_ctrl.sv
// Self-checking bench for fft12_frame_ctrl with a floating-point DFT as the golden core
// and a queue-based frame model; out_tag is checked when FFT12_FRAME_TAG_EN is defined.
module tb_fft12_frame_ctrl;
  import fft12_pkg::*;

  localparam int  W        = 16;
  localparam int  CORE_LAT = 1;
  localparam real PI       = 3.14159265358979323846;

  typedef struct {
    int re;
    int im;
    bit last;
  } smp_t;

  typedef struct {
    int re;
    int im;
    bit last;
    int tag;
    int cyc;
  } bin_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft12_frame_ctrl_if #(.W(W)) fc ();
  logic [12*W-1:0] core_x_re, core_x_im, core_X_re, core_X_im;

  fft12_frame_ctrl #(.W(W), .CORE_LAT(CORE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .fc        (fc),
    .core_x_re (core_x_re),
    .core_x_im (core_x_im),
    .core_X_re (core_X_re),
    .core_X_im (core_X_im)
  );

  // Reference DFT: X[k] = sum x[n] * exp(-j*2*pi*n*k/12), rounded to nearest.
  function automatic int dft_c(input int xr[12], input int xi[12], input int k, input bit imag);
    real sr, si, th, v;
    sr = 0.0;
    si = 0.0;
    for (int n = 0; n < 12; n++) begin
      th = 2.0 * PI * real'(n * k) / 12.0;
      sr = sr + real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
      si = si + real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
    end
    v = imag ? si : sr;
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  int cr[12], ci[12];
  always_comb begin
    for (int k = 0; k < 12; k++) begin
      cr[k] = int'($signed(core_x_re[k*W +: W]));
      ci[k] = int'($signed(core_x_im[k*W +: W]));
    end
  end
  always_comb begin
    core_X_re = '0;
    core_X_im = '0;
    for (int k = 0; k < 12; k++) begin
      core_X_re[k*W +: W] = W'(dft_c(cr, ci, k, 1'b0));
      core_X_im[k*W +: W] = W'(dft_c(cr, ci, k, 1'b1));
    end
  end

  int   errors = 0;
  int   checks = 0;
  smp_t in_q[$];
  bin_t obs_q[$];
  bin_t exp_q[$];
  bin_t stall_obs[$];
  int   cur_re[$], cur_im[$];
  int   exp_err, err_seen, frames_since_rst;
  int   cyc = 0, last_in_cyc;
  int   vld_pct, rdy_pct;
  int   stall_at, stall_left;
  bit   hold_rdy;
  int   hold_cnt, hold_seen, inr_after_last;

  // Frame model: 12 accepted samples form a frame; an early in_last drops the partial frame.
  task automatic model_accept(input smp_t s);
    int xr[12], xi[12];
    if (s.last && cur_re.size() < 11) begin
      cur_re.delete();
      cur_im.delete();
      exp_err++;
    end else begin
      cur_re.push_back(s.re);
      cur_im.push_back(s.im);
      if (cur_re.size() == 12) begin
        if (!s.last) exp_err++;
        for (int n = 0; n < 12; n++) begin
          xr[n] = cur_re[n];
          xi[n] = cur_im[n];
        end
        frames_since_rst++;
        for (int k = 0; k < 12; k++)
          exp_q.push_back('{re: dft_c(xr, xi, k, 1'b0), im: dft_c(xr, xi, k, 1'b1),
                            last: (k == 11), tag: frames_since_rst % 256, cyc: 0});
        cur_re.delete();
        cur_im.delete();
      end
    end
  endtask

  task automatic clear_scn();
    in_q.delete();
    obs_q.delete();
    exp_q.delete();
    stall_obs.delete();
    exp_err = 0;
    err_seen = 0;
    vld_pct = 100;
    rdy_pct = 100;
    stall_at = -1;
    stall_left = 0;
    hold_rdy = 0;
    hold_cnt = 0;
    hold_seen = 0;
    inr_after_last = 0;
  endtask

  task automatic q_smp(input int re, input int im, input bit last);
    in_q.push_back('{re: re, im: im, last: last});
  endtask

  // Cycle driver: drive and sample on the falling edge; transfers happen on the next rising edge.
  task automatic run(input int budget, input int stop_bins);
    bin_t b;
    for (int n = 0; n < budget; n++) begin
      if (stop_bins >= 0 && obs_q.size() == stop_bins) return;
      if (in_q.size() != 0 && $urandom_range(99) < vld_pct) begin
        fc.in_valid = 1'b1;
        fc.in_re    = W'(in_q[0].re);
        fc.in_im    = W'(in_q[0].im);
        fc.in_last  = in_q[0].last;
      end else begin
        fc.in_valid = 1'b0;
        fc.in_re    = W'($urandom);
        fc.in_im    = W'($urandom);
        fc.in_last  = 1'($urandom);
      end
      if (stall_left > 0 && fc.out_valid && obs_q.size() == stall_at) begin
        fc.out_ready = 1'b0;
        stall_left--;
        stall_obs.push_back('{re: int'(fc.out_re), im: int'(fc.out_im), last: fc.out_last,
                              tag: 0, cyc: cyc});
      end else if (hold_rdy) begin
        fc.out_ready = 1'b0;
      end else begin
        fc.out_ready = ($urandom_range(99) < rdy_pct);
      end
      if (fc.in_valid && fc.in_ready) begin
        model_accept(in_q.pop_front());
        last_in_cyc = cyc;
      end
      if (fc.out_valid && fc.out_ready) begin
        b = '{re: int'(fc.out_re), im: int'(fc.out_im), last: fc.out_last, tag: 0, cyc: cyc};
`ifdef FFT12_FRAME_TAG_EN
        b.tag = int'(fc.out_tag);
`endif
        obs_q.push_back(b);
      end
      @(negedge clk);
      cyc++;
      if (fc.err_len) err_seen++;
      if (hold_rdy && in_q.size() == 0) begin
        if (fc.in_ready) inr_after_last++;
        hold_seen++;
        hold_cnt--;
        if (hold_cnt <= 0) hold_rdy = 0;
      end
      if (stop_bins < 0 && in_q.size() == 0 && !hold_rdy && stall_left == 0 &&
          obs_q.size() == exp_q.size() && exp_q.size() != 0) begin
        fc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        cyc += 2;
        if (fc.err_len) err_seen++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL run_timeout: budget=%0d obs=%0d required=%0d", budget, obs_q.size(), exp_q.size());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fc.in_valid = 1'b0;
    fc.in_re = '0;
    fc.in_im = '0;
    fc.in_last = 1'b0;
    fc.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", fc.in_ready); end
    checks++; if (fc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", fc.out_valid); end
    checks++; if (fc.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", fc.out_last); end
    checks++; if (fc.err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len: got %b want 0", fc.err_len); end
    checks++; if (fc.out_re !== '0 || fc.out_im !== '0) begin errors++; $display("FAIL reset_out_data: got %0d/%0d want 0/0", fc.out_re, fc.out_im); end
    checks++; if (core_x_re !== '0 || core_x_im !== '0) begin errors++; $display("FAIL reset_core_x: got %h want 0", core_x_re); end
    rst = 1'b0;
    frames_since_rst = 0;
    cur_re.delete();
    cur_im.delete();
    repeat (2) @(negedge clk);
    cyc += 5;
  endtask

  task automatic test_impulse();
    clear_scn();
    for (int n = 0; n < 12; n++) q_smp(n == 0 ? 1000 : 0, 0, n == 11);
    run(200, -1);
    checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL impulse_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].last !== exp_q[i].last || obs_q[i].re !== 1000)
        begin errors++; $display("FAIL impulse_bin%0d: got %0d/%0d last=%b want %0d/%0d last=%b", i, obs_q[i].re, obs_q[i].im, obs_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last); end
    end
    if (obs_q.size() != 0) begin
      checks++;
      if (obs_q[0].cyc - last_in_cyc !== CORE_LAT + 1)
        begin errors++; $display("FAIL impulse_latency: got %0d want %0d", obs_q[0].cyc - last_in_cyc, CORE_LAT + 1); end
    end
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL impulse_err: got %0d want 0", err_seen); end
  endtask

  task automatic test_dc();
    clear_scn();
    for (int n = 0; n < 12; n++) q_smp(100, 0, n == 11);
    run(200, -1);
    checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL dc_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].last !== exp_q[i].last)
        begin errors++; $display("FAIL dc_bin%0d: got %0d/%0d want %0d/%0d", i, obs_q[i].re, obs_q[i].im, exp_q[i].re, exp_q[i].im); end
    end
    if (obs_q.size() != 0) begin
      checks++; if (obs_q[0].re !== 1200) begin errors++; $display("FAIL dc_bin0_value: got %0d want 1200", obs_q[0].re); end
    end
  endtask

  task automatic test_backpressure();
    clear_scn();
    for (int n = 0; n < 12; n++) q_smp(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000, n == 11);
    stall_at = 3;
    stall_left = 5;
    run(300, -1);
    checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL bp_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].last !== exp_q[i].last)
        begin errors++; $display("FAIL bp_bin%0d: got %0d/%0d want %0d/%0d", i, obs_q[i].re, obs_q[i].im, exp_q[i].re, exp_q[i].im); end
    end
    checks++; if (stall_obs.size() !== 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_obs.size()); end
    for (int i = 0; i < stall_obs.size() && exp_q.size() > 3; i++) begin
      checks++;
      if (stall_obs[i].re !== exp_q[3].re || stall_obs[i].im !== exp_q[3].im || stall_obs[i].last !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d: got %0d/%0d want %0d/%0d", i, stall_obs[i].re, stall_obs[i].im, exp_q[3].re, exp_q[3].im); end
    end
  endtask

  task automatic test_early_last();
    clear_scn();
    for (int n = 0; n < 5; n++) q_smp(int'($urandom_range(600)) - 300, 7, n == 4);
    for (int n = 0; n < 12; n++) q_smp((n % 2 == 0) ? 100 : -100, 0, n == 11);
    run(300, -1);
    checks++; if (err_seen !== 1 || exp_err !== 1) begin errors++; $display("FAIL early_err_pulse: got %0d want 1", err_seen); end
    checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL early_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].last !== exp_q[i].last)
        begin errors++; $display("FAIL early_bin%0d: got %0d/%0d want %0d/%0d", i, obs_q[i].re, obs_q[i].im, exp_q[i].re, exp_q[i].im); end
    end
    if (obs_q.size() > 6) begin
      checks++; if (obs_q[6].re !== 1200) begin errors++; $display("FAIL early_bin6_value: got %0d want 1200", obs_q[6].re); end
    end
    // Twelve samples without in_last: flagged, but the frame is still delivered.
    clear_scn();
    for (int n = 0; n < 12; n++) q_smp(int'($urandom_range(2000)) - 1000, 0, 1'b0);
    run(300, -1);
    checks++; if (err_seen !== 1) begin errors++; $display("FAIL nolast_err_pulse: got %0d want 1", err_seen); end
    checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL nolast_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im)
        begin errors++; $display("FAIL nolast_bin%0d: got %0d/%0d want %0d/%0d", i, obs_q[i].re, obs_q[i].im, exp_q[i].re, exp_q[i].im); end
    end
  endtask

  task automatic test_overlap();
    clear_scn();
    for (int n = 0; n < 24; n++) q_smp(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000, (n % 12) == 11);
    hold_rdy = 1;
    hold_cnt = 8;
    run(400, -1);
    checks++; if (hold_seen !== 8) begin errors++; $display("FAIL overlap_hold: got %0d want 8", hold_seen); end
    checks++; if (inr_after_last !== 0) begin errors++; $display("FAIL overlap_in_ready_full: got %0d cycles ready want 0", inr_after_last); end
    checks++; if (obs_q.size() !== 24) begin errors++; $display("FAIL overlap_count: got %0d want 24", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].last !== exp_q[i].last)
        begin errors++; $display("FAIL overlap_bin%0d: got %0d/%0d want %0d/%0d", i, obs_q[i].re, obs_q[i].im, exp_q[i].re, exp_q[i].im); end
    end
    if (obs_q.size() > 12) begin
      checks++;
      if (obs_q[12].cyc - obs_q[11].cyc !== CORE_LAT + 1)
        begin errors++; $display("FAIL overlap_settle_gap: got %0d want %0d", obs_q[12].cyc - obs_q[11].cyc, CORE_LAT + 1); end
    end
  endtask

  task automatic test_reset_mid();
    clear_scn();
    for (int n = 0; n < 12; n++) q_smp(int'($urandom_range(2000)) - 1000, 0, n == 11);
    run(200, 7);
    rst = 1'b1;
    fc.out_ready = 1'b0;
    fc.in_valid = 1'b0;
    @(negedge clk);
    cyc++;
    checks++; if (fc.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", fc.out_valid); end
    checks++; if (fc.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", fc.in_ready); end
    rst = 1'b0;
    frames_since_rst = 0;
    cur_re.delete();
    cur_im.delete();
    clear_scn();
    for (int n = 0; n < 12; n++) q_smp(n == 2 ? -500 : 0, n == 2 ? 250 : 0, n == 11);
    run(200, -1);
    checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL rstmid_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].last !== exp_q[i].last)
        begin errors++; $display("FAIL rstmid_bin%0d: got %0d/%0d want %0d/%0d", i, obs_q[i].re, obs_q[i].im, exp_q[i].re, exp_q[i].im); end
`ifdef FFT12_FRAME_TAG_EN
      checks++;
      if (obs_q[i].tag !== exp_q[i].tag) begin errors++; $display("FAIL rstmid_tag%0d: got %0d want %0d", i, obs_q[i].tag, exp_q[i].tag); end
`endif
    end
  endtask

  task automatic test_random();
    clear_scn();
    vld_pct = 70;
    rdy_pct = 60;
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 12; n++)
        q_smp(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000, n == 11);
    run(2000, -1);
    checks++; if (obs_q.size() !== 48) begin errors++; $display("FAIL random_count: got %0d want 48", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im || obs_q[i].last !== exp_q[i].last)
        begin errors++; $display("FAIL random_bin%0d: got %0d/%0d last=%b want %0d/%0d last=%b", i, obs_q[i].re, obs_q[i].im, obs_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last); end
`ifdef FFT12_FRAME_TAG_EN
      checks++;
      if (obs_q[i].tag !== exp_q[i].tag) begin errors++; $display("FAIL random_tag%0d: got %0d want %0d", i, obs_q[i].tag, exp_q[i].tag); end
`endif
    end
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL random_err: got %0d want 0", err_seen); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_backpressure();
    test_early_last();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
